ex_mem_stage: RTL

EX/MEM pipeline stage placed directly downstream of the ALU in the pipelined RV32I core. It registers ALU results and control bits for the memory stage, and resolves conditional branches and JAL/JALR using the ALU's 0/1 compare result. It issues a registered PC redirect and squashes the wrong-path instruction in its own shadow. It supports stall (hold) and flush (bubble) from the hazard unit.

---
 rtl/ex_mem_stage.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// ============================================================================
// ex_mem_stage
// ----------------------------------------------------------------------------
// EX/MEM pipeline register for the pipelined RV32I core. The stage sits right
// after the ALU and does four things:
//   * registers the ALU result, store data and control bits for MEM;
//   * resolves conditional branches (from ALU compare bit 0) and JAL/JALR;
//   * issues a one-cycle registered redirect to fetch on a taken transfer;
//   * kills the single wrong-path instruction that follows a taken transfer.
// The hazard unit can hold the stage (stall) or insert a bubble (flush).
// Priority: reset > flush > stall > normal capture.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   stall, flush          hazard-unit hold / bubble requests
//   ex_*                  EX-stage instruction fields and control bits
//   mem_*                 registered instruction fields for MEM
//   redirect_valid/_pc    one-cycle fetch redirect and its target
//   misalign_err          sticky flag: a taken target had bit 1 set
//
// Optional feature
//   EX_MEM_BRANCH_STATS_EN  when defined, adds br_taken_cnt / br_total_cnt
//                           (32-bit wrapping branch statistics counters).
// ============================================================================
module ex_mem_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  ex_valid,
   input  logic [DATA_WIDTH-1:0] ex_pc,
   input  logic [DATA_WIDTH-1:0] ex_imm,
   input  logic [DATA_WIDTH-1:0] ex_alu_result,
   input  logic [DATA_WIDTH-1:0] ex_store_data,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_reg_write,
   input  logic                  ex_mem_read,
   input  logic                  ex_mem_write,
   input  logic [2:0]            ex_funct3,
   input  logic                  ex_branch,
   input  logic                  ex_jal,
   input  logic                  ex_jalr,
   output logic                  mem_valid,
   output logic [DATA_WIDTH-1:0] mem_result,
   output logic [DATA_WIDTH-1:0] mem_store_data,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic                  mem_reg_write,
   output logic                  mem_mem_read,
   output logic                  mem_mem_write,
   output logic [2:0]            mem_funct3,
   output logic                  redirect_valid,
   output logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  misalign_err
`ifdef EX_MEM_BRANCH_STATS_EN
   ,
   output logic [31:0]           br_taken_cnt,
   output logic [31:0]           br_total_cnt
`endif
);

   // SHADOW means the instruction now in EX is on the wrong path of a taken
   // transfer that was captured last cycle and must be killed.
   typedef enum logic {
      RUN    = 1'b0,
      SHADOW = 1'b1
   } state_t;

   state_t state_reg;

   logic                  kill;
   logic                  live;
   logic                  is_jump;
   logic                  taken;
   logic [DATA_WIDTH-1:0] jalr_sum;
   logic [DATA_WIDTH-1:0] target;
   logic [DATA_WIDTH-1:0] pc_plus_4;
   logic [DATA_WIDTH-1:0] result_next;
   logic                  ctrl_en;

   always_comb begin
      kill      = (state_reg == SHADOW);
      live      = ex_valid & ~kill;
      is_jump   = ex_jal | ex_jalr;
      taken     = live & (is_jump | (ex_branch & ex_alu_result[0]));
      jalr_sum  = ex_alu_result + ex_imm;
      pc_plus_4 = ex_pc + DATA_WIDTH'(4);
      // JALR clears bit 0 of its sum; JAL and branches are PC-relative.
      if (ex_jalr)
         target = {jalr_sum[DATA_WIDTH-1:1], 1'b0};
      else
         target = ex_pc + ex_imm;
      result_next = is_jump ? pc_plus_4 : ex_alu_result;
      // Branches never write anything; killed or invalid slots are bubbles.
      ctrl_en = live & ~ex_branch;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= RUN;
         mem_valid      <= 1'b0;
         mem_result     <= '0;
         mem_store_data <= '0;
         mem_rd         <= '0;
         mem_reg_write  <= 1'b0;
         mem_mem_read   <= 1'b0;
         mem_mem_write  <= 1'b0;
         mem_funct3     <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         misalign_err   <= 1'b0;
      end else if (flush) begin
         // Bubble into MEM; any taken transfer in EX this cycle is dropped
         // and a pending redirect is cancelled for good.
         state_reg      <= RUN;
         mem_valid      <= 1'b0;
         mem_reg_write  <= 1'b0;
         mem_mem_read   <= 1'b0;
         mem_mem_write  <= 1'b0;
         redirect_valid <= 1'b0;
      end else if (stall) begin
         // Stage registers hold. The redirect is a pulse, so it still falls
         // after its one cycle rather than being repeated.
         redirect_valid <= 1'b0;
      end else begin
         state_reg      <= taken ? SHADOW : RUN;
         mem_valid      <= live;
         mem_result     <= result_next;
         mem_store_data <= ex_store_data;
         mem_rd         <= ex_rd;
         mem_reg_write  <= ctrl_en & ex_reg_write;
         mem_mem_read   <= ctrl_en & ex_mem_read;
         mem_mem_write  <= ctrl_en & ex_mem_write;
         mem_funct3     <= ex_funct3;
         redirect_valid <= taken;
         if (taken) begin
            // Fetch always receives a word-aligned target; the error is sticky.
            redirect_pc <= {target[DATA_WIDTH-1:2], 2'b00};
            if (target[1])
               misalign_err <= 1'b1;
         end
      end
   end

`ifdef EX_MEM_BRANCH_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         br_taken_cnt <= '0;
         br_total_cnt <= '0;
      end else if (!flush && !stall && live && ex_branch) begin
         br_total_cnt <= br_total_cnt + 32'd1;
         if (ex_alu_result[0])
            br_taken_cnt <= br_taken_cnt + 32'd1;
      end
   end
`endif

endmodule
